// File: rtl/sub_out_arbiter_pkg.sv
// Shared types and defaults for the round-robin out-line arbiter.
package sub_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sub_arb_state_t;

    localparam int SUB_ARB_N_DEFAULT        = 3;
    localparam int SUB_ARB_MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/sub_out_arbiter_if.sv
// Request/grant/data bundle between the sub-module instances and the arbiter.
interface sub_out_arbiter_if #(
    parameter int N = 3
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  din;
    logic [N-1:0]  grant;
    logic [IW-1:0] sel_idx;
    logic          busy;
    logic          out;

    modport master (
        output req, din,
        input  grant, sel_idx, busy, out
    );

    modport slave (
        input  req, din,
        output grant, sel_idx, busy, out
    );
endinterface

// File: rtl/sub_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning last+1, last+2, ... mod N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] win,
    output logic          found
);

    // Scan from the far end so the nearest candidate after 'last' is written last.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sub_out_arbiter.sv
// Round-robin owner of the shared out line; optional forced hand-off under SUB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant held, out driven to 0
// GRANT | one owner holds the grant, out follows its din one cycle late
module sub_out_arbiter
    import sub_arb_pkg::*;
#(
    parameter int N        = SUB_ARB_N_DEFAULT,
    parameter int MAX_HOLD = SUB_ARB_MAX_HOLD_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    sub_out_arbiter_if.slave bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    sub_arb_state_t state_q, state_nxt;
    logic [N-1:0]   grant_q, grant_nxt;
    logic [IW-1:0]  sel_q, sel_nxt;
    logic [IW-1:0]  last_q, last_nxt;
    logic           out_q;
    logic [IW-1:0]  win;
    logic           found;

`ifdef SUB_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold_q, hold_nxt;
`endif

    // Masking the owner's own request makes the same pick serve release and timeout hand-off.
    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (bus.req & ~grant_q),
        .last  (last_q),
        .win   (win),
        .found (found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= IW'(N - 1);
            out_q   <= 1'b0;
`ifdef SUB_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            sel_q   <= sel_nxt;
            last_q  <= last_nxt;
            out_q   <= (state_q == GRANT) ? bus.din[sel_q] : 1'b0;
`ifdef SUB_ARB_TIMEOUT_EN
            hold_q  <= hold_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        sel_nxt   = sel_q;
        last_nxt  = last_q;
`ifdef SUB_ARB_TIMEOUT_EN
        hold_nxt  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_nxt      = GRANT;
                    grant_nxt      = '0;
                    grant_nxt[win] = 1'b1;
                    sel_nxt        = win;
                    last_nxt       = win;
`ifdef SUB_ARB_TIMEOUT_EN
                    hold_nxt       = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    if (found) begin
                        grant_nxt      = '0;
                        grant_nxt[win] = 1'b1;
                        sel_nxt        = win;
                        last_nxt       = win;
`ifdef SUB_ARB_TIMEOUT_EN
                        hold_nxt       = '0;
`endif
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end
`ifdef SUB_ARB_TIMEOUT_EN
                else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    if (found) begin
                        grant_nxt      = '0;
                        grant_nxt[win] = 1'b1;
                        sel_nxt        = win;
                        last_nxt       = win;
                        hold_nxt       = '0;
                    end
                end else begin
                    hold_nxt = hold_q + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.sel_idx = sel_q;
    assign bus.busy    = (state_q == GRANT);
    assign bus.out     = out_q;

endmodule
